mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the execute stage, between the EX/MEM and MEM/WB pipeline registers. It accepts one load or store per request, models a fixed multi-cycle data RAM, performs byte/halfword/word alignment with sign or zero extension, and raises `busy` so the pipeline stalls until the access completes. It also flags misaligned accesses instead of touching memory.

## Interface
- `DEPTH`, 1024: data RAM size in 32-bit words; power of two.
- `LATENCY`, 2: cycles `busy` stays high per legal access; must be at least 1.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `is_load`  in  1  EX/MEM holds a load.
- `is_store`  in  1  EX/MEM holds a store; `is_load` and `is_store` never both 1.
- `load_type`  in  3  funct3 code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `store_type`  in  3  funct3 code: 000 SB, 001 SH, 010 SW.
- `addr`  in  32  byte address, taken from the ALU result.
- `store_data`  in  32  rs2 value; the low byte or halfword is used for SB/SH.
- `busy`  out  1  stall request to the pipeline (combinational).
- `resp_valid`  out  1  one-cycle pulse when the access completes.
- `load_data`  out  32  extended load result; valid while `resp_valid` is 1.
- `misaligned`  out  1  one-cycle pulse alongside `resp_valid` for a misaligned access.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Request: `is_load` or `is_store` is 1 while the FSM is in IDLE. On a request, the unit latches the type, `addr`, and `store_data`.
- Word index is `addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Misalignment rules:
  - Halfword: LH, LHU, or SH with `addr[0]`=1.
  - Word: LW or SW with `addr[1:0]` not equal to 00.
  - Illegal funct3 codes (011, 110, 111 for loads; anything other than 000, 001, 010 for stores) are also treated as misaligned.
- IDLE transitions:
  - Legal request: go to WAIT with countdown = LATENCY-1. If LATENCY=1, go directly to DONE.
  - Misaligned request: go to DONE with the error recorded. No RAM read or write happens.
- WAIT: decrement the counter each cycle. At 0, go to DONE.
- DONE: then return to IDLE. The request inputs are ignored in DONE, because the EX/MEM register still presents the old request that cycle.
- Store commit: on the WAIT-to-DONE edge (or the IDLE-to-DONE edge when LATENCY=1), only the addressed byte lanes are written:
  - SB: the lane selected by `addr[1:0]`.
  - SH: lanes {1,0} or {3,2}, selected by `addr[1]`.
  - SW: all 4 lanes.
- Load result: captured on the same edge from the addressed lanes.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Misaligned loads and all stores return `load_data` = 0.
- RAM contents are not cleared by reset and power up as 0 in simulation.

## Timing
- `busy` = (IDLE and request present) or WAIT. It is high in the request cycle itself, so EX/MEM, ID/EX, and IF/ID hold at that edge.
- Legal access presented in cycle T:
  - `busy` is high in cycles T through T+LATENCY-1.
  - In cycle T+LATENCY the FSM is in DONE, `busy`=0, and `resp_valid`=1. `load_data` is valid only in that DONE cycle and is held stable until the next completion.
  - The pipeline advances at the end of cycle T+LATENCY, so MEM/WB captures `load_data` at that edge.
- Misaligned access presented in cycle T: `busy` is high for 1 cycle; `resp_valid`=1 and `misaligned`=1 in cycle T+1.
- Back-to-back memory operations: a new request seen in IDLE in cycle T+LATENCY+1 is accepted normally. Throughput is one access per LATENCY+1 cycles.
- Cycles with no request: `busy`=0 and `resp_valid`=0.
- Reset (synchronous, honoured in any state): next state is IDLE; `busy`, `resp_valid`, `misaligned`, and `load_data` all go to 0. A store still in flight is discarded and never written.
- A store followed by a load to the same word returns the newly stored data, since the write commits before the load's request is accepted.

## Test plan
- SW of 0xDEADBEEF to 0x100, then LW from 0x100. Required: `busy` high for 2 cycles each (LATENCY=2), and `load_data`=0xDEADBEEF together with `resp_valid`.
- Word 0x80 holds 0x8011F2A3. Required results:
  - LB from 0x80 returns 0xFFFFFFA3.
  - LBU from 0x81 returns 0x000000F2.
  - LH from 0x82 returns 0xFFFF8011.
  - LHU from 0x82 returns 0x00008011.
- Byte-lane writes: SB 0x55 to 0x203 over an existing 0x11223344, then LW from 0x200. Required: 0x55223344. A following SH of 0xAAAA to 0x200 makes the word 0x5522AAAA.
- Misalignment: LW from 0x102 and SH to 0x105. Required: `busy` high for 1 cycle, `misaligned`=1 and `load_data`=0, and the RAM word at 0x104 is unchanged.
- Reset and wrap-around:
  - Assert `reset` in WAIT during an SW to 0x40. Required: next cycle all outputs are 0 and the FSM is IDLE; a later LW from 0x40 returns the old value.
  - With DEPTH=1024, SW to 0x1000 followed by LW from 0x0 returns the stored value.
- Sweep LATENCY=1 and LATENCY=4. Required: `busy` high for exactly LATENCY cycles; a request held through DONE is not re-accepted, giving exactly one `resp_valid` per access.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: multi-cycle data RAM with lane alignment, sign/zero extension and misalignment detection.
// States: IDLE (accepting requests) | WAIT (access in flight) | DONE (response cycle, request inputs ignored).
module mem_access_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          is_load_q;
    logic [2:0]    type_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   data_q;
    logic          resp_valid_q;
    logic          misaligned_q;
    logic [31:0]   load_data_q;
    logic [31:0]   mem_q [DEPTH];

    logic          idle, req, mis_req, commit, we;
    logic          acc_load;
    logic [2:0]    acc_type, req_type;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_data, rdata, rd_result, wdata;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [3:0]    be;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^addr[31:AW+2];

    function automatic logic mis_check(input logic ld, input logic [2:0] t, input logic [1:0] a);
        case (t)
            3'b000:  mis_check = 1'b0;
            3'b001:  mis_check = a[0];
            3'b010:  mis_check = |a;
            3'b100:  mis_check = !ld;
            3'b101:  mis_check = ld ? a[0] : 1'b1;
            default: mis_check = 1'b1;
        endcase
    endfunction

    assign idle     = (state_q == IDLE);
    assign req      = idle && (is_load || is_store);
    assign busy     = req || (state_q == WAIT);
    assign req_type = is_load ? load_type : store_type;
    assign mis_req  = mis_check(is_load, req_type, addr[1:0]);

    // With LATENCY=1 the access completes on the accept edge, so the live inputs drive the RAM port.
    always_comb begin
        if (idle) begin
            acc_load = is_load;
            acc_type = req_type;
            acc_addr = addr[AW+1:0];
            acc_data = store_data;
        end else begin
            acc_load = is_load_q;
            acc_type = type_q;
            acc_addr = addr_q;
            acc_data = data_q;
        end
    end

    assign rdata  = mem_q[acc_addr[AW+1:2]];
    assign commit = ((state_q == WAIT) && (cnt_q == CW'(1))) ||
                    (req && !mis_req && (LATENCY == 1));
    assign we     = commit && !acc_load && !reset;

    always_comb begin
        case (acc_addr[1:0])
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = acc_addr[1] ? rdata[31:16] : rdata[15:0];
        case (acc_type)
            3'b000:  rd_result = {{24{rbyte[7]}}, rbyte};
            3'b001:  rd_result = {{16{rhalf[15]}}, rhalf};
            3'b010:  rd_result = rdata;
            3'b100:  rd_result = {24'b0, rbyte};
            3'b101:  rd_result = {16'b0, rhalf};
            default: rd_result = 32'b0;
        endcase
        if (!acc_load) rd_result = 32'b0;
    end

    always_comb begin
        case (acc_type[1:0])
            2'b00: begin
                be    = 4'b0001 << acc_addr[1:0];
                wdata = {4{acc_data[7:0]}};
            end
            2'b01: begin
                be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{acc_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = acc_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[acc_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            type_q       <= 3'b0;
            addr_q       <= '0;
            data_q       <= 32'b0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= 32'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    misaligned_q <= 1'b0;
                    if (req) begin
                        is_load_q <= is_load;
                        type_q    <= req_type;
                        addr_q    <= addr[AW+1:0];
                        data_q    <= store_data;
                        if (mis_req) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            misaligned_q <= 1'b1;
                            load_data_q  <= 32'b0;
                        end else if (LATENCY == 1) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            load_data_q  <= rd_result;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        load_data_q  <= rd_result;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    misaligned_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign misaligned = misaligned_q;
    assign load_data  = load_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table on a LATENCY=2 instance, reset/wrap sequences, and LATENCY=1/4 sweeps.
module tb_mem_access_unit;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset, is_load, is_store;
    logic [2:0]  load_type, store_type;
    logic [31:0] addr, store_data;
    int          sel;
    logic        busy_w [3];
    logic        resp_w [3];
    logic        mis_w  [3];
    logic [31:0] ld_w   [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic        m;
        string       nm;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       nm;
        logic        ld;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic        exp_m;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_unit #(
            .DEPTH  (1024),
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .is_load   (is_load && (sel == g)),
            .is_store  (is_store && (sel == g)),
            .load_type (load_type),
            .store_type(store_type),
            .addr      (addr),
            .store_data(store_data),
            .busy      (busy_w[g]),
            .resp_valid(resp_w[g]),
            .load_data (ld_w[g]),
            .misaligned(mis_w[g])
        );
    end

    function automatic int lat(input int k);
        lat = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    function automatic vec_t v(input string nm, input logic ld, input logic [2:0] t,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_d, input logic exp_m);
        vec_t r;
        r.nm = nm; r.ld = ld; r.t = t; r.a = a; r.d = d; r.exp_d = exp_d; r.exp_m = exp_m;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (resp_w[k]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: inst %0d got resp_valid 1 expected no response", k);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("%s/load_data", e.nm), ld_w[k], e.d);
                    check($sformatf("%s/misaligned", e.nm), {31'b0, mis_w[k]}, {31'b0, e.m});
                end
            end
        end
    end

    task automatic access(input int k, input string nm, input logic ld, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_m);
        exp_t e;
        int   nb;
        bit   got;
        @(posedge clk); #1;
        e.d = exp_d; e.m = exp_m; e.nm = nm;
        sb.push_back(e);
        sel = k; is_load = ld; is_store = !ld;
        load_type = t; store_type = t; addr = a; store_data = d;
        nb = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (busy_w[k]) nb++;
            if (resp_w[k]) got = 1'b1;
        end
        check($sformatf("%s/responded", nm), {31'b0, got}, 32'd1);
        check($sformatf("%s/busy_cycles", nm), nb, exp_m ? 32'd1 : lat(k));
        @(posedge clk); #1;
        is_load = 1'b0; is_store = 1'b0;
        @(negedge clk);
        check($sformatf("%s/busy_after", nm), {31'b0, busy_w[k]}, 32'd0);
        check($sformatf("%s/no_reaccept", nm), {31'b0, resp_w[k]}, 32'd0);
        check($sformatf("%s/data_hold", nm), ld_w[k], exp_d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(v("sw_100",   1'b0, F_W,  32'h100,  32'hDEADBEEF, 32'h0,        1'b0));
        vecs.push_back(v("lw_100",   1'b1, F_W,  32'h100,  32'h0,        32'hDEADBEEF, 1'b0));
        vecs.push_back(v("lbu_103",  1'b1, F_BU, 32'h103,  32'h0,        32'h000000DE, 1'b0));
        vecs.push_back(v("sw_80",    1'b0, F_W,  32'h80,   32'h8011F2A3, 32'h0,        1'b0));
        vecs.push_back(v("lb_80",    1'b1, F_B,  32'h80,   32'h0,        32'hFFFFFFA3, 1'b0));
        vecs.push_back(v("lbu_81",   1'b1, F_BU, 32'h81,   32'h0,        32'h000000F2, 1'b0));
        vecs.push_back(v("lb_81",    1'b1, F_B,  32'h81,   32'h0,        32'hFFFFFFF2, 1'b0));
        vecs.push_back(v("lh_82",    1'b1, F_H,  32'h82,   32'h0,        32'hFFFF8011, 1'b0));
        vecs.push_back(v("lhu_82",   1'b1, F_HU, 32'h82,   32'h0,        32'h00008011, 1'b0));
        vecs.push_back(v("lh_80",    1'b1, F_H,  32'h80,   32'h0,        32'hFFFFF2A3, 1'b0));
        vecs.push_back(v("sw_200",   1'b0, F_W,  32'h200,  32'h11223344, 32'h0,        1'b0));
        vecs.push_back(v("sb_203",   1'b0, F_B,  32'h203,  32'hFFFFFF55, 32'h0,        1'b0));
        vecs.push_back(v("lw_200a",  1'b1, F_W,  32'h200,  32'h0,        32'h55223344, 1'b0));
        vecs.push_back(v("sh_200",   1'b0, F_H,  32'h200,  32'h1234AAAA, 32'h0,        1'b0));
        vecs.push_back(v("lw_200b",  1'b1, F_W,  32'h200,  32'h0,        32'h5522AAAA, 1'b0));
        vecs.push_back(v("sw_104",   1'b0, F_W,  32'h104,  32'hA5A5A5A5, 32'h0,        1'b0));
        vecs.push_back(v("lw_102",   1'b1, F_W,  32'h102,  32'h0,        32'h0,        1'b1));
        vecs.push_back(v("sh_105",   1'b0, F_H,  32'h105,  32'h0000FFFF, 32'h0,        1'b1));
        vecs.push_back(v("sw_106",   1'b0, F_W,  32'h106,  32'h0,        32'h0,        1'b1));
        vecs.push_back(v("st_f3_3",  1'b0, 3'b011, 32'h104, 32'h0,       32'h0,        1'b1));
        vecs.push_back(v("ld_f3_6",  1'b1, 3'b110, 32'h104, 32'h0,       32'h0,        1'b1));
        vecs.push_back(v("lw_104",   1'b1, F_W,  32'h104,  32'h0,        32'hA5A5A5A5, 1'b0));
        vecs.push_back(v("sw_1000",  1'b0, F_W,  32'h1000, 32'h0BADF00D, 32'h0,        1'b0));
        vecs.push_back(v("lw_0",     1'b1, F_W,  32'h0,    32'h0,        32'h0BADF00D, 1'b0));

        reset = 1'b1; is_load = 1'b0; is_store = 1'b0; sel = 0;
        load_type = 3'b0; store_type = 3'b0; addr = 32'h0; store_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d/busy", k), {31'b0, busy_w[k]}, 32'd0);
            check($sformatf("reset%0d/resp_valid", k), {31'b0, resp_w[k]}, 32'd0);
            check($sformatf("reset%0d/misaligned", k), {31'b0, mis_w[k]}, 32'd0);
            check($sformatf("reset%0d/load_data", k), ld_w[k], 32'd0);
        end
        reset = 1'b0;

        foreach (vecs[i])
            access(0, vecs[i].nm, vecs[i].ld, vecs[i].t, vecs[i].a, vecs[i].d,
                   vecs[i].exp_d, vecs[i].exp_m);

        // Reset while an SW to 0x40 sits in WAIT: the store must be dropped.
        access(0, "rst_pre_sw", 1'b0, F_W, 32'h40, 32'h12345678, 32'h0, 1'b0);
        access(0, "rst_pre_lw", 1'b1, F_W, 32'h40, 32'h0, 32'h12345678, 1'b0);
        @(posedge clk); #1;
        sel = 0; is_store = 1'b1; store_type = F_W; addr = 32'h40; store_data = 32'hCAFEBABE;
        @(posedge clk); #1;
        reset = 1'b1; is_store = 1'b0;
        @(negedge clk);
        check("rst/busy_in_wait", {31'b0, busy_w[0]}, 32'd1);
        @(negedge clk);
        check("rst/busy", {31'b0, busy_w[0]}, 32'd0);
        check("rst/resp_valid", {31'b0, resp_w[0]}, 32'd0);
        check("rst/misaligned", {31'b0, mis_w[0]}, 32'd0);
        check("rst/load_data", ld_w[0], 32'd0);
        reset = 1'b0;
        access(0, "rst_post_lw", 1'b1, F_W, 32'h40, 32'h0, 32'h12345678, 1'b0);

        for (int k = 1; k < 3; k++) begin
            access(k, $sformatf("lat%0d_sw", lat(k)),  1'b0, F_W,  32'h10, 32'h11111111, 32'h0, 1'b0);
            access(k, $sformatf("lat%0d_lw", lat(k)),  1'b1, F_W,  32'h10, 32'h0, 32'h11111111, 1'b0);
            access(k, $sformatf("lat%0d_lh_mis", lat(k)), 1'b1, F_H, 32'h11, 32'h0, 32'h0, 1'b1);
            access(k, $sformatf("lat%0d_sb", lat(k)),  1'b0, F_B,  32'h12, 32'h0000007F, 32'h0, 1'b0);
            access(k, $sformatf("lat%0d_lw2", lat(k)), 1'b1, F_W,  32'h10, 32'h0, 32'h117F1111, 1'b0);
            access(k, $sformatf("lat%0d_lhu", lat(k)), 1'b1, F_HU, 32'h12, 32'h0, 32'h0000117F, 1'b0);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
